// File: rtl/ntt_bu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_bu_pipe
//  Purpose  : Forward Cooley-Tukey NTT butterfly for the Dilithium ring,
//             a' = (a + w*b) mod Q and b' = (a - w*b) mod Q, Q = 8380417.
//             Four-stage pipeline under valid/ready with a pass-through tag.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_bu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int Val_Q      = 8380417,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] ntt_data1_o,
  output logic [DATA_WIDTH-1:0] ntt_data2_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  range_err_o
);

  localparam logic [23:0]           Q24   = 24'(Val_Q);
  localparam logic [DATA_WIDTH-1:0] Q_EXT = DATA_WIDTH'(Val_Q);

  // Whole pipeline moves together; it only freezes when a result is blocked.
  logic advance;
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  logic range_hit;
  assign range_hit = (a_i >= Q_EXT) || (b_i >= Q_EXT) || (w_i >= Q_EXT);

  // Stage registers
  logic                 s1_valid, s2_valid, s3_valid;
  logic [22:0]          s1_a, s1_b, s1_w, s2_a, s3_a, s3_m;
  logic [TAG_WIDTH-1:0] s1_tag, s2_tag, s3_tag;
  logic [45:0]          s2_p;
  logic                 range_err;
  logic [22:0]          out1, out2;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_valid;

  // S1: capture operands (truncated to 23 bits) and flag out-of-range inputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_w      <= '0;
      s1_tag    <= '0;
      range_err <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid_i;
      s1_a     <= a_i[22:0];
      s1_b     <= b_i[22:0];
      s1_w     <= w_i[22:0];
      s1_tag   <= tag_i;
      if (in_valid_i && range_hit) range_err <= 1'b1;
    end
  end

  // S2: full 46-bit product w*b
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_p     <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_a     <= s1_a;
      s2_p     <= 46'(s1_w) * 46'(s1_b);
      s2_tag   <= s1_tag;
    end
  end

  // Shift-add folding using 2^23 == 2^13 - 1 (mod Q); three folds bring the
  // product below 2Q, then one conditional subtract makes it exact.
  logic [22:0] hi1, lo1, l2, l3, m_red;
  logic [12:0] h2;
  logic [3:0]  h3;
  logic [35:0] x1;
  logic [26:0] x2;
  logic [23:0] x3;

  // Combinational reduction of the S2 product
  always_comb begin
    hi1   = s2_p[45:23];
    lo1   = s2_p[22:0];
    x1    = {hi1, 13'd0} - 36'(hi1) + 36'(lo1);
    h2    = x1[35:23];
    l2    = x1[22:0];
    x2    = {1'b0, h2, 13'd0} - 27'(h2) + 27'(l2);
    h3    = x2[26:23];
    l3    = x2[22:0];
    x3    = {7'd0, h3, 13'd0} - 24'(h3) + 24'(l3);
    m_red = (x3 >= Q24) ? 23'(x3 - Q24) : x3[22:0];
  end

  // S3: register the reduced product m = w*b mod Q
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s3_valid <= 1'b0;
      s3_a     <= '0;
      s3_m     <= '0;
      s3_tag   <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      s3_a     <= s2_a;
      s3_m     <= m_red;
      s3_tag   <= s2_tag;
    end
  end

  logic [23:0] sum;
  logic [22:0] res1, res2;

  // Modular add/sub, each with a single conditional correction
  always_comb begin
    sum  = {1'b0, s3_a} + {1'b0, s3_m};
    res1 = (sum >= Q24) ? 23'(sum - Q24) : sum[22:0];
    res2 = (s3_a < s3_m) ? 23'({1'b0, s3_a} + Q24 - {1'b0, s3_m})
                         : (s3_a - s3_m);
  end

  // S4: output registers; data only reloads when a real result moves in
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out1    <= res1;
        out2    <= res2;
        out_tag <= s3_tag;
      end
    end
  end

  assign out_valid_o = out_valid;
  assign ntt_data1_o = DATA_WIDTH'(out1);
  assign ntt_data2_o = DATA_WIDTH'(out2);
  assign tag_o       = out_tag;
  assign range_err_o = range_err;

endmodule
`default_nettype wire
